// File: rtl/mips_store_pkg.sv
// mips_store_pkg: shared encodings and types for the MIPS store path
package mips_store_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } st_size_e;

    typedef enum logic {
        IDLE,
        ISSUE
    } drain_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } st_entry_t;

endpackage

// File: rtl/store_lane_fmt.sv
// store_lane_fmt: alignment check and byte-lane formatting of one store
module store_lane_fmt
    import mips_store_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  size_i,
    output logic        misalign_o,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o
);

    logic [3:0] be_byte;
    logic [3:0] be_half;

    // big-endian mirrors the lane order; replicated data is the same either way
    always_comb begin
        be_byte    = BIG_ENDIAN ? (4'b1000 >> addr_i[1:0]) : (4'b0001 << addr_i[1:0]);
        be_half    = (addr_i[1] ^ BIG_ENDIAN) ? 4'b1100 : 4'b0011;
        be_o       = (size_i == SZ_BYTE) ? be_byte : (size_i == SZ_HALF) ? be_half : 4'b1111;
        wdata_o    = (size_i == SZ_BYTE) ? {4{data_i[7:0]}} :
                     (size_i == SZ_HALF) ? {2{data_i[15:0]}} : data_i;
        misalign_o = (size_i == SZ_RSVD) ||
                     (size_i == SZ_HALF && addr_i[0]) ||
                     (size_i == SZ_WORD && addr_i[1:0] != 2'b00);
    end

endmodule

// File: rtl/mips_store_unit.sv
// mips_store_unit: buffered store path from EX/MEM to data memory
module mips_store_unit
    import mips_store_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_size,
    output logic        misalign,
    output logic [31:0] misalign_addr,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    st_entry_t    store_q [DEPTH];
    st_entry_t    head;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    drain_state_e state_q;
    logic         misalign_q;
    logic [31:0]  misalign_addr_q;
    logic         fmt_bad;
    logic [31:0]  fmt_wdata;
    logic [3:0]   fmt_be;
    logic         accept;
    logic         push;
    logic         pop;

    store_lane_fmt #(.BIG_ENDIAN(BIG_ENDIAN)) u_fmt (
        .addr_i     (st_addr),
        .data_i     (st_data),
        .size_i     (st_size),
        .misalign_o (fmt_bad),
        .wdata_o    (fmt_wdata),
        .be_o       (fmt_be)
    );

    // handshake, occupancy and the head entry driven while a write is outstanding
    always_comb begin
        st_ready      = count_q != CW'(DEPTH);
        accept        = st_valid && st_ready;
        push          = accept && !fmt_bad;
        pop           = state_q == ISSUE && mem_ack;
        count_d       = count_q + CW'(push) - CW'(pop);
        head          = store_q[rd_ptr_q];
        mem_req       = state_q == ISSUE;
        mem_addr      = mem_req ? head.addr : '0;
        mem_wdata     = mem_req ? head.wdata : '0;
        mem_be        = mem_req ? head.be : '0;
        empty         = count_q == '0 && state_q == IDLE;
        misalign      = misalign_q;
        misalign_addr = misalign_addr_q;
    end

    // entries are written already formatted; reset only needs to clear the pointers
    always_ff @(posedge clk) begin
        if (push)
            store_q[wr_ptr_q] <= '{addr: {st_addr[31:2], 2'b00}, wdata: fmt_wdata, be: fmt_be};
    end

    // pointers, count, drain FSM and the reject pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            state_q         <= IDLE;
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_q + AW'(push);
            rd_ptr_q   <= rd_ptr_q + AW'(pop);
            count_q    <= count_d;
            misalign_q <= accept && fmt_bad;
            if (accept && fmt_bad)
                misalign_addr_q <= st_addr;
            if (state_q == IDLE)
                state_q <= (count_q != '0) ? ISSUE : IDLE;
            else
                state_q <= (pop && count_d == '0) ? IDLE : ISSUE;
        end
    end

endmodule

// File: tb/tb_mips_store_unit.sv
// tb_mips_store_unit: randomized and directed checks against a queue-based model
module tb_mips_store_unit;

    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  le;
        logic [3:0]  be;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st_valid = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [1:0]  st_size = '0;
    logic        mem_ack = 1'b0;
    logic        st_ready, misalign, mem_req, empty;
    logic [31:0] misalign_addr, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        b_ready, b_mis, b_req, b_empty;
    logic [31:0] b_maddr, b_addr, b_wdata;
    logic [3:0]  b_be;

    exp_t        q[$];
    logic        exp_req = 1'b0;
    logic        exp_mis = 1'b0;
    logic [31:0] exp_maddr = '0;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    mips_store_unit #(.DEPTH(DEPTH), .BIG_ENDIAN(1'b0)) u_dut (
        .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
        .misalign(misalign), .misalign_addr(misalign_addr),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .empty(empty)
    );

    mips_store_unit #(.DEPTH(DEPTH), .BIG_ENDIAN(1'b1)) u_be (
        .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(b_ready),
        .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
        .misalign(b_mis), .misalign_addr(b_maddr),
        .mem_req(b_req), .mem_ack(mem_ack), .mem_addr(b_addr),
        .mem_wdata(b_wdata), .mem_be(b_be), .empty(b_empty)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic is_bad(input logic [31:0] a, input logic [1:0] sz);
        return sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    endfunction

    function automatic exp_t fmt(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        exp_t e;
        int off = int'(a % 4);
        e.a = a - 32'(off);
        if (sz == 2'd0) begin
            e.d  = 32'(d[7:0]) * 32'h01010101;
            e.le = 4'(1 << off);
            e.be = 4'(8 >> off);
        end else if (sz == 2'd1) begin
            e.d  = 32'(d[15:0]) * 32'h00010001;
            e.le = (off >= 2) ? 4'd12 : 4'd3;
            e.be = (off >= 2) ? 4'd3 : 4'd12;
        end else begin
            e.d  = d;
            e.le = 4'd15;
            e.be = 4'd15;
        end
        return e;
    endfunction

    // one clock: check visible state, apply inputs across the edge, advance the model
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic ack);
        logic acc, pop;
        int pre;
        st_valid = v; st_addr = a; st_data = d; st_size = sz; mem_ack = ack;
        #1;
        check("st_ready", 32'(st_ready), 32'(q.size() != DEPTH));
        check("mem_req", 32'(mem_req), 32'(exp_req));
        check("be_mem_req", 32'(b_req), 32'(exp_req));
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("misalign", 32'(misalign), 32'(exp_mis));
        check("misalign_addr", misalign_addr, exp_maddr);
        if (exp_req) begin
            check("mem_addr", mem_addr, q[0].a);
            check("mem_wdata", mem_wdata, q[0].d);
            check("mem_be", 32'(mem_be), 32'(q[0].le));
            check("be_mem_be", 32'(b_be), 32'(q[0].be));
        end
        acc = v && q.size() != DEPTH;
        pop = exp_req && ack;
        pre = q.size();
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        if (acc && !is_bad(a, sz)) q.push_back(fmt(a, d, sz));
        exp_mis = acc && is_bad(a, sz);
        if (exp_mis) exp_maddr = a;
        exp_req = exp_req ? q.size() > 0 : pre > 0;
    endtask

    task automatic idle(input int n, input logic ack);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 2'd0, ack);
    endtask

    task automatic do_reset();
        rst = 1'b1; st_valid = 1'b0; mem_ack = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        exp_req = 1'b0; exp_mis = 1'b0; exp_maddr = '0;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
    endtask

    initial begin
        do_reset();
        idle(2, 1'b1);
        step(1'b1, 32'h00001003, 32'h000000A5, 2'd0, 1'b1);
        idle(3, 1'b1);
        step(1'b1, 32'h00002002, 32'h1234BEEF, 2'd1, 1'b1);
        idle(3, 1'b1);
        step(1'b1, 32'h00003001, 32'h11111111, 2'd2, 1'b1);
        step(1'b1, 32'h00003001, 32'h22222222, 2'd1, 1'b1);
        step(1'b1, 32'h00003000, 32'h33333333, 2'd3, 1'b1);
        idle(2, 1'b1);
        step(1'b1, 32'h00000010, 32'hA0000010, 2'd2, 1'b0);
        step(1'b1, 32'h00000014, 32'hA0000014, 2'd2, 1'b0);
        step(1'b1, 32'h00000018, 32'hA0000018, 2'd2, 1'b0);
        step(1'b1, 32'h00000018, 32'hA0000018, 2'd2, 1'b0);
        step(1'b1, 32'h00000018, 32'hA0000018, 2'd2, 1'b1);
        step(1'b1, 32'h00000018, 32'hA0000018, 2'd2, 1'b0);
        idle(5, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 32'h00004000 + 32'(i), 32'(8'h30 + i), 2'd0, 1'b1);
        idle(6, 1'b1);
        step(1'b1, 32'h00005000, 32'hDEAD0001, 2'd2, 1'b0);
        step(1'b1, 32'h00005004, 32'hDEAD0002, 2'd2, 1'b0);
        idle(2, 1'b0);
        do_reset();
        idle(4, 1'b1);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            step($urandom_range(0, 3) != 0, $urandom & 32'h0000FFFF, $urandom,
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        idle(8, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_store_unit.md
# mips_store_unit

Store path of the MIPS32 data-memory stage, the write-side counterpart of the load sign/zero-extension logic. It takes SB/SH/SW requests from the EX/MEM pipeline register and narrows the 32-bit register value onto the correct byte lanes with byte enables. It traps misaligned accesses, buffers up to DEPTH stores, and drains them to data memory over a req/ack handshake, so memory wait states do not stall the pipeline until the buffer fills.

## Interface
- DEPTH, 2, store-buffer entries (power of two, ≥2)
- BIG_ENDIAN, 0, 0 = little-endian lane mapping, 1 = big-endian
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- st_valid  in  1  store request present
- st_ready  out  1  unit can accept; equals "buffer not full"
- st_addr  in  32  byte address
- st_data  in  32  rt register value
- st_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- misalign  out  1  one-cycle pulse: rejected store
- misalign_addr  out  32  address of the last rejected store
- mem_req  out  1  write request to data memory
- mem_ack  in  1  memory accepted current write
- mem_addr  out  32  word-aligned address ({st_addr[31:2],2'b00})
- mem_wdata  out  32  lane-replicated write data
- mem_be  out  4  byte enables, bit i = byte lane i (bits [8i+7:8i])
- empty  out  1  buffer empty and no request outstanding

## Operation
- A store is accepted when st_valid && st_ready at a clock edge.
- Alignment check on an accepted store:
  - Half with addr[0]=1 is misaligned.
  - Word with addr[1:0]≠0 is misaligned.
  - Size 11 is rejected.
  - A rejected store is not enqueued. misalign=1 in the next cycle only, and misalign_addr loads st_addr at the same time.
- Formatting, little-endian (off = addr[1:0]):
  - Byte: wdata={4{d[7:0]}}, be=4'b0001<<off.
  - Half: wdata={2{d[15:0]}}, be=addr[1]?4'b1100:4'b0011.
  - Word: wdata=d, be=4'b1111.
- Big-endian formatting: byte be=4'b1000>>off; half be=addr[1]?4'b0011:4'b1100; data replication is unchanged.
- The buffer is a circular FIFO with wr/rd pointers of log2(DEPTH) bits plus a count. Pointers wrap modulo DEPTH. Entries store {mem_addr, wdata, be}, already formatted.
- Drain FSM:
  - IDLE: mem_req=0. If count>0 on the edge, go to ISSUE.
  - ISSUE: mem_req=1. mem_addr/wdata/be come from the head entry and stay stable until ack.
  - On mem_ack in ISSUE: pop the head. Stay in ISSUE if count-1>0 (back-to-back), otherwise go to IDLE.
  - mem_ack outside ISSUE is ignored.
- Simultaneous push and pop: both happen and count is unchanged. st_ready is driven from the registered count only; a pop does not make room in the same cycle.
- empty = (count==0) && state==IDLE.

## Timing
- Reset values:
  - st_ready=1, mem_req=0, misalign=0, empty=1.
  - misalign_addr, mem_addr, mem_wdata, mem_be = 0.
  - count=0, pointers=0, state=IDLE.
- Reset mid-operation: all buffered and outstanding stores are discarded. mem_req is 0 in the cycle after the reset edge, even if mem_ack was pending.
- Latency: a store accepted at edge N into an empty unit gives mem_req=1 in cycle N+1 (one-cycle buffer latency).
- Throughput: one store per cycle with mem_ack held high.
- A full buffer (count==DEPTH) drops st_ready in the cycle after the filling edge. st_ready returns in the cycle after the pop.
- misalign is a pulse even for back-to-back rejects: it is high in each following cycle, and misalign_addr updates each time.

## Structure
- Package mips_store_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD
  - drain FSM state type {IDLE, ISSUE}
  - buffer entry struct (addr, wdata, be)
- Sub-module store_lane_fmt: combinational alignment check plus wdata/be generation, parameterised by BIG_ENDIAN. It is reused by the future cache write path.
- FIFO storage and the FSM stay inline in mips_store_unit.

## Test plan
- SB addr 0x00001003, data 0x000000A5, LE, ack held high → mem_req in cycle N+1, mem_addr 0x00001000, wdata 0xA5A5A5A5, be 4'b1000.
- SH addr 0x00002002, data 0x1234BEEF → wdata 0xBEEFBEEF, be 4'b1100. Same store with BIG_ENDIAN=1 → be 4'b0011.
- SW addr 0x00003001 → misalign=1 for exactly one cycle, misalign_addr 0x00003001, no mem_req, empty stays 1. SH to 0x3001 gives the same result.
- mem_ack held low, three SWs to 0x10/0x14/0x18 → first two accepted, st_ready=0. mem_req stays on 0x10 and its data is stable. Pulse ack → 0x14 presented next cycle, st_ready=1, third store accepted. Drain order is 0x10, 0x14, 0x18.
- Ack held high, eight consecutive SBs to rising addresses → one write per cycle, in order. Pointers wrap, count never exceeds DEPTH.
- Two stores buffered, mem_req high, rst asserted one cycle → next cycle mem_req=0, empty=1, st_ready=1. No stale write issues after reset.
